// File: rtl/pc_seq_unit_pkg.sv
// Shared definitions for the fetch-stage PC sequencer: FSM encoding, default
// vectors and the alignment mask helper.
package pc_seq_unit_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } pc_state_t;

  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VEC  = 32'h0000_0100;

  // Mask of the low target bits that must be zero; zero bits gives an empty mask.
  function automatic logic [63:0] align_mask(input int bits);
    return (64'd1 << bits) - 64'd1;
  endfunction

endpackage

// File: rtl/pc_seq_unit_if.sv
// Bus between the PC sequencer (master) and the control/fetch side (slave).
// Handshake: a fetch address transfers on any rising clk edge where valid and
// ready are both high; while valid=1 and ready=0 the pc is held stable except
// when a trap or redirect flushes it.
interface pc_seq_unit_if #(
  parameter int XLEN = 32
);
  logic            ready;
  logic            redir_valid;
  logic [XLEN-1:0] redir_target;
  logic            trap;
  logic            halt;
  logic            resume;
  logic            valid;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus;
  logic            misalign;
  logic            halted;

  modport master (
    input  ready, redir_valid, redir_target, trap, halt, resume,
    output valid, pc, pc_plus, misalign, halted
  );

  modport slave (
    output ready, redir_valid, redir_target, trap, halt, resume,
    input  valid, pc, pc_plus, misalign, halted
  );
endinterface

// File: rtl/pc_incr.sv
// Combinational PC incrementer; wraps modulo 2^XLEN with no carry out.
module pc_incr #(
  parameter int XLEN = 32,
  parameter int STEP = 4
) (
  input  logic [XLEN-1:0] a,
  output logic [XLEN-1:0] sum
);
  assign sum = a + XLEN'(STEP);
endmodule

// File: rtl/pc_seq_unit.sv
// Fetch-stage program-counter sequencer: BOOT/RUN/HALT FSM, PC register,
// trap > redirect > halt > advance priority mux and redirect alignment check.
module pc_seq_unit
  import pc_seq_unit_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter int              STEP       = 4,
  parameter logic [XLEN-1:0] RESET_VEC  = XLEN'(DEF_RESET_VEC),
  parameter logic [XLEN-1:0] TRAP_VEC   = XLEN'(DEF_TRAP_VEC),
  parameter int              ALIGN_BITS = 2
) (
  input  logic               clk,
  input  logic               rst,
  pc_seq_unit_if.master      bus,
  output pc_state_t          state
);

  localparam logic [63:0]     MASK_WIDE  = align_mask(ALIGN_BITS);
  localparam logic [XLEN-1:0] ALIGN_MASK = MASK_WIDE[XLEN-1:0];

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_next_seq;
  logic            valid_q;
  logic            misalign_q;
  logic            halted_q;
  logic            target_bad;

  pc_incr #(.XLEN(XLEN), .STEP(STEP)) u_incr (
    .a   (pc_q),
    .sum (pc_next_seq)
  );

  assign target_bad = |(bus.redir_target & ALIGN_MASK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_BOOT;
      pc_q       <= RESET_VEC;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      misalign_q <= 1'b0;
      case (state)
        ST_BOOT: begin
          state    <= ST_RUN;
          valid_q  <= 1'b1;
          halted_q <= 1'b0;
        end
        ST_RUN: begin
          if (bus.trap) begin
            pc_q <= TRAP_VEC;
          end else if (bus.redir_valid) begin
            if (target_bad) begin
              pc_q       <= TRAP_VEC;
              misalign_q <= 1'b1;
            end else begin
              pc_q <= bus.redir_target;
            end
          end else if (bus.halt) begin
            // The fetch offered in this cycle still completes before halting.
            if (bus.ready) pc_q <= pc_next_seq;
            state    <= ST_HALT;
            valid_q  <= 1'b0;
            halted_q <= 1'b1;
          end else if (bus.ready) begin
            pc_q <= pc_next_seq;
          end
        end
        ST_HALT: begin
          if (bus.trap) begin
            pc_q     <= TRAP_VEC;
            state    <= ST_RUN;
            valid_q  <= 1'b1;
            halted_q <= 1'b0;
          end else begin
            if (bus.redir_valid) begin
              if (target_bad) begin
                pc_q       <= TRAP_VEC;
                misalign_q <= 1'b1;
              end else begin
                pc_q <= bus.redir_target;
              end
            end
            if (bus.resume && !bus.halt) begin
              state    <= ST_RUN;
              valid_q  <= 1'b1;
              halted_q <= 1'b0;
            end
          end
        end
        default: begin
          state    <= ST_BOOT;
          valid_q  <= 1'b0;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pc       = pc_q;
  assign bus.pc_plus  = pc_next_seq;
  assign bus.valid    = valid_q;
  assign bus.misalign = misalign_q;
  assign bus.halted   = halted_q;

endmodule

// File: tb/tb_pc_seq_unit.sv
// Directed bench for pc_seq_unit: reset/boot, backpressure, redirect/trap,
// misalign, halt/resume and wraparound.
module tb_pc_seq_unit;
  import pc_seq_unit_pkg::*;

  logic      clk;
  logic      rst;
  pc_state_t state;
  int        errors;
  int        checks;

  pc_seq_unit_if #(.XLEN(32)) bus ();

  pc_seq_unit dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus.master),
    .state (state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and sample 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.ready        = 1'b0;
    bus.redir_valid  = 1'b0;
    bus.redir_target = 32'h0;
    bus.trap         = 1'b0;
    bus.halt         = 1'b0;
    bus.resume       = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    step();
    rst = 1'b0;
    bus.ready = 1'b1;
    repeat (3) step();
    // Mid-run async reset: outputs must drop without waiting for a clock.
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.pc !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h want %h", bus.pc, 32'h0); end
    checks++;
    if (bus.valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", bus.valid); end
    checks++;
    if (state !== ST_BOOT) begin errors++; $display("FAIL rst_state: got %0d want %0d", state, ST_BOOT); end
    step();
    // Release with trap/redirect asserted: BOOT must ignore them.
    rst = 1'b0;
    bus.ready = 1'b0;
    bus.trap = 1'b1;
    bus.redir_valid = 1'b1;
    bus.redir_target = 32'h300;
    step();
    idle_inputs();
    checks++;
    if (bus.valid !== 1'b1) begin errors++; $display("FAIL boot_valid: got %b want 1", bus.valid); end
    checks++;
    if (bus.pc !== 32'h0) begin errors++; $display("FAIL boot_ignores: got %h want %h", bus.pc, 32'h0); end
    checks++;
    if (bus.pc_plus !== 32'h4) begin errors++; $display("FAIL boot_pc_plus: got %h want %h", bus.pc_plus, 32'h4); end
    bus.ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++;
      if (bus.pc !== 32'(i * 4)) begin errors++; $display("FAIL advance_%0d: got %h want %h", i, bus.pc, 32'(i * 4)); end
    end
  endtask

  task automatic test_backpressure();
    step();
    checks++;
    if (bus.pc !== 32'h10) begin errors++; $display("FAIL bp_start: got %h want %h", bus.pc, 32'h10); end
    bus.ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (bus.pc !== 32'h10 || bus.valid !== 1'b1) begin
        errors++; $display("FAIL bp_hold_%0d: got pc=%h valid=%b want pc=10 valid=1", i, bus.pc, bus.valid);
      end
    end
    bus.ready = 1'b1;
    step();
    checks++;
    if (bus.pc !== 32'h14) begin errors++; $display("FAIL bp_release: got %h want %h", bus.pc, 32'h14); end
    bus.ready = 1'b0;
  endtask

  task automatic test_redirect_trap();
    bus.redir_valid = 1'b1;
    bus.redir_target = 32'h200;
    step();
    checks++;
    if (bus.pc !== 32'h200) begin errors++; $display("FAIL redir_no_ready: got %h want %h", bus.pc, 32'h200); end
    bus.redir_target = 32'h400;
    bus.trap = 1'b1;
    step();
    idle_inputs();
    checks++;
    if (bus.pc !== 32'h100) begin errors++; $display("FAIL trap_over_redir: got %h want %h", bus.pc, 32'h100); end
    checks++;
    if (bus.misalign !== 1'b0) begin errors++; $display("FAIL trap_no_misalign: got %b want 0", bus.misalign); end
  endtask

  task automatic test_misalign();
    bus.redir_valid = 1'b1;
    bus.redir_target = 32'h202;
    step();
    idle_inputs();
    checks++;
    if (bus.pc !== 32'h100) begin errors++; $display("FAIL misalign_pc: got %h want %h", bus.pc, 32'h100); end
    checks++;
    if (bus.misalign !== 1'b1) begin errors++; $display("FAIL misalign_pulse: got %b want 1", bus.misalign); end
    step();
    checks++;
    if (bus.misalign !== 1'b0) begin errors++; $display("FAIL misalign_clear: got %b want 0", bus.misalign); end
  endtask

  task automatic test_halt_resume();
    bus.redir_valid = 1'b1;
    bus.redir_target = 32'h40;
    step();
    idle_inputs();
    bus.ready = 1'b1;
    bus.halt = 1'b1;
    step();
    bus.halt = 1'b0;
    checks++;
    if (bus.pc !== 32'h44 || bus.valid !== 1'b0 || bus.halted !== 1'b1) begin
      errors++; $display("FAIL halt_enter: got pc=%h valid=%b halted=%b want pc=44 valid=0 halted=1", bus.pc, bus.valid, bus.halted);
    end
    checks++;
    if (state !== ST_HALT) begin errors++; $display("FAIL halt_state: got %0d want %0d", state, ST_HALT); end
    bus.redir_valid = 1'b1;
    bus.redir_target = 32'h80;
    step();
    bus.redir_valid = 1'b0;
    checks++;
    if (bus.pc !== 32'h80 || bus.halted !== 1'b1) begin
      errors++; $display("FAIL halt_redir: got pc=%h halted=%b want pc=80 halted=1", bus.pc, bus.halted);
    end
    step();
    checks++;
    if (bus.pc !== 32'h80) begin errors++; $display("FAIL halt_no_advance: got %h want %h", bus.pc, 32'h80); end
    bus.resume = 1'b1;
    bus.halt = 1'b1;
    step();
    checks++;
    if (bus.halted !== 1'b1) begin errors++; $display("FAIL resume_with_halt: got halted=%b want 1", bus.halted); end
    bus.halt = 1'b0;
    step();
    bus.resume = 1'b0;
    checks++;
    if (bus.valid !== 1'b1 || bus.halted !== 1'b0 || bus.pc !== 32'h80) begin
      errors++; $display("FAIL resume: got pc=%h valid=%b halted=%b want pc=80 valid=1 halted=0", bus.pc, bus.valid, bus.halted);
    end
    step();
    checks++;
    if (bus.pc !== 32'h84) begin errors++; $display("FAIL resume_fetch: got %h want %h", bus.pc, 32'h84); end
    bus.halt = 1'b1;
    step();
    bus.halt = 1'b0;
    bus.ready = 1'b0;
    bus.trap = 1'b1;
    step();
    bus.trap = 1'b0;
    checks++;
    if (bus.pc !== 32'h100 || state !== ST_RUN || bus.valid !== 1'b1) begin
      errors++; $display("FAIL halt_trap: got pc=%h state=%0d valid=%b want pc=100 state=1 valid=1", bus.pc, state, bus.valid);
    end
  endtask

  task automatic test_wrap();
    bus.redir_valid = 1'b1;
    bus.redir_target = 32'hFFFF_FFFC;
    step();
    idle_inputs();
    checks++;
    if (bus.pc !== 32'hFFFF_FFFC || bus.pc_plus !== 32'h0) begin
      errors++; $display("FAIL wrap_pre: got pc=%h plus=%h want pc=fffffffc plus=0", bus.pc, bus.pc_plus);
    end
    bus.ready = 1'b1;
    step();
    bus.ready = 1'b0;
    checks++;
    if (bus.pc !== 32'h0 || bus.pc_plus !== 32'h4) begin
      errors++; $display("FAIL wrap: got pc=%h plus=%h want pc=0 plus=4", bus.pc, bus.pc_plus);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_backpressure();
    test_redirect_trap();
    test_misalign();
    test_halt_resume();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
